// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the x^4+x^3+1 Fibonacci PRBS stream.
// It self-synchronises on the incoming bits, declares lock after a run of
// correct predictions, then counts bit errors. An all-zero shift register
// always counts as a mismatch, so a line stuck at 0 cannot hold lock.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FILL   | loading 4 received bits into sr, no comparisons made
// SYNC   | counting consecutive correct predictions toward lock
// LOCKED | counting errors; consecutive misses drop back to FILL
module lfsr_checker #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_det
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     sr;
    logic [1:0]     fill_left;   // valid bits still to load, minus one
    logic [MW-1:0]  match_left;  // correct predictions still needed for lock
    logic [LW-1:0]  miss_left;   // consecutive misses still tolerated

    logic           pred;
    logic           bad;
    logic [3:0]     sr_nxt;
    logic           fill_done;
    logic           lose_lock;
    logic           in_fill_nxt;

    // Prediction, mismatch and next-cycle shift register / FILL occupancy.
    always_comb begin
        pred        = sr[3] ^ sr[2];
        bad         = (in_bit != pred) || (sr == 4'b0000);
        sr_nxt      = in_valid ? {sr[2:0], in_bit} : sr;
        fill_done   = in_valid && (state == FILL) && (fill_left == 2'd0);
        lose_lock   = in_valid && (state == LOCKED) && bad && (miss_left == LW'(1));
        in_fill_nxt = ((state == FILL) && !fill_done) || lose_lock;
    end

    // Sync FSM with shift register, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            sr         <= 4'b0000;
            fill_left  <= 2'd3;
            match_left <= '0;
            miss_left  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            zero_det   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            zero_det  <= (sr_nxt == 4'b0000) && !in_fill_nxt;
            if (clear) begin
                err_count <= '0;
            end
            if (in_valid) begin
                sr <= sr_nxt;
                case (state)
                    FILL: begin
                        if (fill_left == 2'd0) begin
                            state      <= SYNC;
                            match_left <= MW'(LOCK_COUNT);
                        end else begin
                            fill_left <= fill_left - 2'd1;
                        end
                    end
                    SYNC: begin
                        if (bad) begin
                            match_left <= MW'(LOCK_COUNT);
                        end else if (match_left == MW'(1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            miss_left <= LW'(LOSS_COUNT);
                        end else begin
                            match_left <= match_left - MW'(1);
                        end
                    end
                    LOCKED: begin
                        if (bad) begin
                            err_pulse <= 1'b1;
                            // A clear coinciding with an error leaves that error counted.
                            if (clear) begin
                                err_count <= ERR_W'(1);
                            end else if (err_count != {ERR_W{1'b1}}) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (miss_left == LW'(1)) begin
                                state     <= FILL;
                                locked    <= 1'b0;
                                fill_left <= 2'd3;
                            end else begin
                                miss_left <= miss_left - LW'(1);
                            end
                        end else begin
                            miss_left <= LW'(LOSS_COUNT);
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
